operand_loader: RTL and testbench
=================================

// Module: operand_loader
// PURPOSE
//   Upstream operand sequencer for the 8-bit ripple-carry adder datapath.
//   Takes the raw load push-button and the operand/carry switches, then
//   synchronises and debounces the button.
//   Successive presses capture operand A, then operand B plus carry-in, into
//   registers that drive the adder's A, B and cin inputs directly.
//   Flags when a complete operand pair is held, so the result display can qualify it.
// PARAMETERS
//   WIDTH            8        operand width in bits (sw, a_out, b_out)
//   DEBOUNCE_CYCLES  500000   cycles the synchronised button must differ from its stable level before the change is accepted (>=2)
// PORTS
//   clk        input   1      system clock; all state changes on its rising edge
//   rst_n      input   1      asynchronous, active-low reset
//   btn_raw    input   1      raw load push-button, asynchronous, bouncy, active-high
//   sw         input   WIDTH  operand switches, quasi-static, sampled on the accepted press cycle
//   cin_sw     input   1      carry-in switch, sampled together with operand B
//   clr        input   1      synchronous clear, active-high, single-cycle or level
//   a_out      output  WIDTH  captured operand A to the adder
//   b_out      output  WIDTH  captured operand B to the adder
//   cin_out    output  1      captured carry-in to the adder
//   state      output  2      00 = LOAD_A, 01 = LOAD_B, 10 = READY (LED indication)
//   op_valid   output  1      high while in READY (A, B and cin all captured)
//   new_op     output  1      one-cycle pulse on the first cycle of READY
// BEHAVIOUR
//   Reset (rst_n=0, async)
//     - a_out, b_out = 0; cin_out, op_valid, new_op = 0; state = LOAD_A.
//     - Both sync flops, the stable level and the debounce counter are cleared to 0.
//   Synchroniser
//     - btn_raw passes through 2 flops to give btn_s.
//     - sw and cin_sw are not synchronised; they must be stable in the press cycle.
//   Debounce
//     - If btn_s == stable, cnt <= 0.
//     - Otherwise cnt increments. When cnt == DEBOUNCE_CYCLES-1: stable <= btn_s, cnt <= 0.
//     - Any bounce back to the stable level restarts the count.
//     - A button held through reset release is debounced to 1 and counts as a press.
//   Press detect
//     - press is a single-cycle pulse on a stable 0->1 transition.
//     - Release (1->0) produces no event.
//     - Holding the button produces exactly one press.
//   Latency
//     - Clean btn_raw rise at cycle 0: press pulses at cycle 2+DEBOUNCE_CYCLES.
//     - Captured registers, state and op_valid update at the next edge.
//   FSM (events evaluated only when press = 1)
//     - LOAD_A --press--> LOAD_B:  a_out <= sw.
//     - LOAD_B --press--> READY:   b_out <= sw, cin_out <= cin_sw; new_op = 1 for one cycle.
//     - READY  --press--> LOAD_B:  a_out <= sw; b_out and cin_out are held; op_valid drops.
//   clr
//     - In any state: state <= LOAD_A and a_out, b_out, cin_out <= 0.
//     - clr has priority over a press in the same cycle; that press is discarded.
//     - Debounce state is not affected by clr.
//   Output mapping
//     - op_valid = (state == READY); registered, no combinational path from inputs.
//     - Outputs change only on a press or clr; the captured value is held indefinitely otherwise.
// TESTING (bench uses DEBOUNCE_CYCLES=4)
//   1. Reset: rst_n=0 mid-cycle -> all outputs 0 and state=00 immediately, with no clock edge needed.
//   2. Full load
//      - sw=8'h3C, clean press -> a_out=3C, state=01.
//      - sw=8'hA5, cin_sw=1, press -> b_out=A5, cin_out=1, state=10, op_valid=1.
//      - new_op is high for exactly 1 cycle.
//   3. Bounce: btn_raw toggles every 2 cycles for 20 cycles, then holds 1 -> exactly one press, 6 cycles after the last toggle.
//   4. Hold and release: button held 100 cycles, then released -> one capture only; state advances by exactly 1.
//   5. Reload from READY: in READY press with sw=8'h0F -> a_out=0F, b_out=A5 kept, state=01, op_valid=0.
//   6. clr vs press: clr=1 in the same cycle as press (state=01, sw=8'hFF) -> state=00, a_out=b_out=0, cin_out=0, no capture.

Source files
------------

// File: rtl/operand_loader.sv
// Operand sequencer for the 8-bit adder: debounces the load button and captures
// operand A, then operand B with carry-in, on successive presses.
module operand_loader #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_raw,
   input  logic [WIDTH-1:0] sw,
   input  logic             cin_sw,
   input  logic             clr,
   output logic [WIDTH-1:0] a_out,
   output logic [WIDTH-1:0] b_out,
   output logic             cin_out,
   output logic [1:0]       state,
   output logic             op_valid,
   output logic             new_op
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {
      ST_LOAD_A = 2'b00,
      ST_LOAD_B = 2'b01,
      ST_READY  = 2'b10
   } state_t;

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_stable_d;
   logic [CNT_W-1:0] r_cnt;
   logic             w_press;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_cin;
   logic             r_op_valid;
   logic             r_new_op;
   logic [WIDTH-1:0] w_a_nxt;
   logic [WIDTH-1:0] w_b_nxt;
   logic             w_cin_nxt;
   logic             w_new_op_nxt;

   // Two-flop synchroniser and debounce; a level is accepted only after it
   // has differed from the stable level for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_stable   <= 1'b0;
         r_stable_d <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_sync1    <= btn_raw;
         r_sync2    <= r_sync1;
         r_stable_d <= r_stable;
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign w_press = r_stable & ~r_stable_d;

   // State and captured-operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_LOAD_A;
         r_a        <= '0;
         r_b        <= '0;
         r_cin      <= 1'b0;
         r_op_valid <= 1'b0;
         r_new_op   <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_a        <= w_a_nxt;
         r_b        <= w_b_nxt;
         r_cin      <= w_cin_nxt;
         r_op_valid <= (w_state_nxt == ST_READY);
         r_new_op   <= w_new_op_nxt;
      end
   end

   // Next state; clr wins over a press in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      if (clr) begin
         w_state_nxt = ST_LOAD_A;
      end else if (w_press) begin
         case (r_state)
            ST_LOAD_A: w_state_nxt = ST_LOAD_B;
            ST_LOAD_B: w_state_nxt = ST_READY;
            default:   w_state_nxt = ST_LOAD_B;
         endcase
      end
   end

   // Capture values for the operand registers
   always_comb begin
      w_a_nxt      = r_a;
      w_b_nxt      = r_b;
      w_cin_nxt    = r_cin;
      w_new_op_nxt = 1'b0;
      if (clr) begin
         w_a_nxt   = '0;
         w_b_nxt   = '0;
         w_cin_nxt = 1'b0;
      end else if (w_press) begin
         case (r_state)
            ST_LOAD_A: w_a_nxt = sw;
            ST_LOAD_B: begin
               w_b_nxt      = sw;
               w_cin_nxt    = cin_sw;
               w_new_op_nxt = 1'b1;
            end
            default:   w_a_nxt = sw;
         endcase
      end
   end

   assign a_out    = r_a;
   assign b_out    = r_b;
   assign cin_out  = r_cin;
   assign state    = r_state;
   assign op_valid = r_op_valid;
   assign new_op   = r_new_op;

endmodule

// File: tb/tb_operand_loader.sv
// Bench for operand_loader: directed scenarios plus random button/clr traffic,
// every cycle compared against an event-level reference model.
module tb_operand_loader;

   localparam int unsigned DEB = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       btn_raw;
   logic [7:0] sw;
   logic       cin_sw;
   logic       clr;
   logic [7:0] a_out;
   logic [7:0] b_out;
   logic       cin_out;
   logic [1:0] state;
   logic       op_valid;
   logic       new_op;

   operand_loader #(.WIDTH(8), .DEBOUNCE_CYCLES(DEB)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_raw  (btn_raw),
      .sw       (sw),
      .cin_sw   (cin_sw),
      .clr      (clr),
      .a_out    (a_out),
      .b_out    (b_out),
      .cin_out  (cin_out),
      .state    (state),
      .op_valid (op_valid),
      .new_op   (new_op)
   );

   always #5 clk = ~clk;

   int n_checks  = 0;
   int n_pass    = 0;
   int n_changes = 0;
   int new_cnt   = 0;
   logic [1:0] prev_state = 2'b00;

   // Reference model: button samples delayed two cycles, a level is accepted
   // after DEB consecutive differing samples, a rise becomes a press that the
   // sequencer acts on one cycle later.
   logic       m_s1, m_s2, m_stable, m_press, m_new;
   int         m_run, m_phase;
   logic [7:0] m_a, m_b;
   logic       m_cin;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [31:0] dut_pack();
      return {11'd0, new_op, op_valid, state, cin_out, b_out, a_out};
   endfunction

   function automatic logic [31:0] model_pack();
      return {11'd0, m_new, (m_phase == 2), 2'(m_phase), m_cin, m_b, m_a};
   endfunction

   task automatic model_reset();
      m_s1 = 0; m_s2 = 0; m_stable = 0; m_press = 0; m_new = 0;
      m_run = 0; m_phase = 0; m_a = 0; m_b = 0; m_cin = 0;
   endtask

   task automatic model_step(input logic raw, input logic [7:0] s, input logic c, input logic cl);
      logic btn_s;
      btn_s = m_s2;
      m_new = 0;
      if (cl) begin
         m_phase = 0; m_a = 0; m_b = 0; m_cin = 0;
      end else if (m_press) begin
         if (m_phase == 1) begin
            m_b = s; m_cin = c; m_phase = 2; m_new = 1;
         end else begin
            m_a = s; m_phase = 1;
         end
      end
      m_press = 0;
      if (btn_s != m_stable) m_run++;
      else m_run = 0;
      if (m_run == int'(DEB)) begin
         m_press  = btn_s & ~m_stable;
         m_stable = btn_s;
         m_run    = 0;
      end
      m_s2 = m_s1;
      m_s1 = raw;
   endtask

   task automatic tick();
      logic r, c, cl;
      logic [7:0] s;
      r = btn_raw; s = sw; c = cin_sw; cl = clr;
      @(posedge clk);
      model_step(r, s, c, cl);
      #1;
      chk("outs", dut_pack(), model_pack());
      if (state !== prev_state) n_changes++;
      prev_state = state;
      if (new_op) new_cnt++;
   endtask

   task automatic wait_change(input int max, output int n);
      logic [1:0] s0;
      s0 = state;
      n = 0;
      while (state == s0 && n <= max) begin
         tick();
         n++;
      end
   endtask

   task automatic release_btn();
      btn_raw = 1'b0;
      repeat (DEB + 6) tick();
   endtask

   task automatic async_reset();
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_async", dut_pack(), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold", dut_pack(), 32'd0);
      rst_n = 1'b1;
      prev_state = state;
   endtask

   initial begin
      int n;
      rst_n = 1'b0; btn_raw = 1'b0; sw = 8'h00; cin_sw = 1'b0; clr = 1'b0;
      model_reset();
      #12;
      chk("reset", dut_pack(), 32'd0);
      rst_n = 1'b1;

      // Full load with latency check
      sw = 8'h3C; btn_raw = 1'b1;
      wait_change(20, n);
      chk("lat_a", 32'(n), 32'd7);
      chk("a_3c", {24'd0, a_out}, 32'h3C);
      chk("st_b", {30'd0, state}, 32'd1);
      release_btn();
      sw = 8'hA5; cin_sw = 1'b1; new_cnt = 0; btn_raw = 1'b1;
      wait_change(20, n);
      chk("lat_b", 32'(n), 32'd7);
      release_btn();
      chk("b_a5", {23'd0, cin_out, b_out}, 32'h1A5);
      chk("st_rdy", {29'd0, op_valid, state}, 32'b110);
      chk("new_op_1", 32'(new_cnt), 32'd1);

      // Bounce: 2-cycle toggles never qualify, final hold does exactly once
      n_changes = 0;
      for (int i = 0; i < 10; i++) begin
         btn_raw = ~btn_raw;
         repeat (2) tick();
      end
      btn_raw = 1'b1;
      wait_change(20, n);
      chk("lat_bounce", 32'(n), 32'd7);
      release_btn();
      chk("bounce_one", 32'(n_changes), 32'd1);

      // Hold and release yields a single capture
      n_changes = 0;
      btn_raw = 1'b1;
      repeat (100) tick();
      release_btn();
      chk("hold_one", 32'(n_changes), 32'd1);
      chk("hold_rdy", {30'd0, state}, 32'd2);

      // Reload from READY
      sw = 8'h0F; cin_sw = 1'b0; btn_raw = 1'b1;
      wait_change(20, n);
      release_btn();
      chk("reload", {29'd0, op_valid, state, cin_out, b_out, a_out}, {14'd0, 1'b0, 2'd1, 1'b1, 8'hA5, 8'h0F});

      // clr in the press cycle discards the press
      sw = 8'hFF; btn_raw = 1'b1;
      repeat (6) tick();
      chk("pre_clr", {30'd0, state}, 32'd1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("clr_press", dut_pack(), 32'd0);
      repeat (10) tick();
      release_btn();
      chk("clr_nocap", dut_pack(), 32'd0);

      // Random traffic against the model
      repeat (80) begin
         case ($urandom_range(0, 4))
            0, 1: begin
               sw = 8'($urandom); cin_sw = 1'($urandom);
               btn_raw = 1'b1;
               repeat ($urandom_range(DEB, 12)) tick();
               btn_raw = 1'b0;
               repeat ($urandom_range(DEB + 2, 10)) tick();
            end
            2: begin
               repeat ($urandom_range(1, 4)) begin
                  btn_raw = 1'b1;
                  repeat ($urandom_range(1, 3)) tick();
                  btn_raw = 1'b0;
                  repeat ($urandom_range(1, 3)) tick();
               end
            end
            3: begin
               clr = 1'b1;
               repeat ($urandom_range(1, 2)) tick();
               clr = 1'b0;
               tick();
            end
            default: begin
               sw = 8'($urandom); btn_raw = 1'b1;
               repeat ($urandom_range(2, 10)) begin
                  clr = 1'($urandom);
                  sw  = 8'($urandom);
                  tick();
               end
               clr = 1'b0;
               release_btn();
            end
         endcase
         if ($urandom_range(0, 15) == 0) async_reset();
      end

      // Mid-cycle async reset with loaded operands
      release_btn();
      sw = 8'h5A; btn_raw = 1'b1;
      wait_change(20, n);
      chk("pre_rst", {31'd0, (a_out == 8'h5A) || (b_out == 8'h5A)}, 32'd1);
      async_reset();
      release_btn();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
